// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, frame constants and timeout helper for the PS/2 receiver
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  function automatic int unsigned timeout_cycles(input int unsigned freq_hz,
                                                 input int unsigned timeout_us);
    return (freq_hz / 1_000_000) * timeout_us;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - 2-flop synchroniser followed by a persistence glitch filter
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(FILTER_LEN);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level only moves after FILTER_LEN samples in a row disagree with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 device-to-host frame receiver producing scan code, strobe and error pulses
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FREQ_HZ    = 25_000_000,
  parameter int          FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       strobe_o,
  output logic       err_o
);

  localparam int unsigned TIMEOUT_CYC = timeout_cycles(FREQ_HZ, TIMEOUT_US);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(DATA_BITS);

  logic clk_lvl, data_lvl, clk_prev_q, fall;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset_n_i(reset_n_i), .raw_i(ps2_clk_i), .level_o(clk_lvl)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .reset_n_i(reset_n_i), .raw_i(ps2_data_i), .level_o(data_lvl)
  );

  // Fall is seen in the same cycle the filtered clock first reads low.
  assign fall = clk_prev_q & ~clk_lvl;

  ps2_state_t           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [7:0]           code_q, code_d;
  logic                 strobe_q, strobe_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tmo_cnt_d = tmo_cnt_q;
    code_d    = code_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      tmo_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!data_lvl) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_lvl, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_lvl;
          state_d  = STOP;
        end
        STOP: begin
          if (data_lvl && (^{shift_q, parity_q})) begin
            code_d   = shift_q;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // Stalled frame: drop the partial data and report once.
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (tmo_cnt_d == TW'(TIMEOUT_CYC)) begin
        err_d     = 1'b1;
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      code_q     <= 8'h00;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_prev_q <= clk_lvl;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      tmo_cnt_q  <= tmo_cnt_d;
      code_q     <= code_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign code_o   = code_q;
  assign strobe_o = strobe_q;
  assign err_o    = err_q;

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver that deserialises device-to-host frames from the raw PS/2 clock/data lines. It is the stage directly upstream of the SoC keyboard input and drives its code/strobe/error triple. Each valid frame gives one 8-bit scan code with a single-cycle strobe. Malformed or stalled frames give a single-cycle error pulse instead.

## Interface
- FREQ_HZ, 25_000_000, system clock frequency in Hz
- FILTER_LEN, 8, consecutive stable samples required before a filtered line changes level (≥2)
- TIMEOUT_US, 2000, maximum time between PS/2 clock falling edges inside a frame
- clk  input  1  system clock; all logic is in this single domain
- reset_n_i  input  1  reset, asynchronous assert, active-low
- ps2_clk_i  input  1  raw PS/2 clock line, asynchronous
- ps2_data_i  input  1  raw PS/2 data line, asynchronous
- code_o  output  8  last valid scan code; holds its value until the next valid frame
- strobe_o  output  1  one-cycle pulse when code_o has just been updated
- err_o  output  1  one-cycle pulse on a framing, parity or timeout error

## Operation
- Both lines pass through a 2-flop synchroniser and then a glitch filter.
  - Each filter keeps a counter that resets on every sample equal to the filtered level.
  - The filtered level flips after FILTER_LEN consecutive differing samples.
  - Filtered levels reset to 1.
- A fall event is the cycle in which the filtered clock goes from 1 to 0.
  - Data is sampled from the filtered data line in that same cycle.
- Frame format is 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM states:
  - IDLE: on a fall with data=0, go to DATA and clear the bit counter. On a fall with data=1, stay in IDLE silently.
  - DATA: shift data in, LSB first. After the 8th fall, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on a fall, check the frame. If the stop bit is 1 and the parity is odd (^{data,parity} == 1), load code_o and pulse strobe_o. Otherwise pulse err_o and leave code_o unchanged. Always return to IDLE.
- Timeout:
  - TIMEOUT_CYC = FREQ_HZ/1_000_000 × TIMEOUT_US; counter width is $clog2(TIMEOUT_CYC+1).
  - The counter runs in every non-IDLE state and is cleared on each fall.
  - When it reaches TIMEOUT_CYC, pulse err_o and go to IDLE. The partial frame is discarded.
- strobe_o and err_o are never high in the same cycle.
- The block is receive-only: the PS/2 lines are never driven.

## Timing
- Reset values: code_o=8'h00, strobe_o=0, err_o=0, FSM=IDLE, all counters 0, synchroniser and filter outputs 1.
- Latency: a raw falling edge at cycle 0 that stays stable produces its fall event at cycle FILTER_LEN+2.
  - strobe_o or err_o is registered high at cycle FILTER_LEN+3.
  - The pulse lasts exactly 1 cycle.
- Reset asserted mid-frame aborts immediately and asynchronously: no strobe, no err.
  - After release, the first fall event is treated as a possible start bit.
- Back-to-back frames need no idle gap. The next start-bit fall may arrive as early as the cycle after the STOP fall.
- Timeout and a fall event in the same cycle: the fall wins and the counter clears.

## Structure
- Package ps2_pkg holds:
  - the state enum ps2_state_t {IDLE, DATA, PARITY, STOP};
  - FRAME_BITS=11 and DATA_BITS=8;
  - a function computing TIMEOUT_CYC from FREQ_HZ and TIMEOUT_US.
- Sub-module ps2_filter (synchroniser plus glitch filter, parameter FILTER_LEN) is instantiated twice, once per line.
- The FSM, shift register, bit counter and timeout counter live in ps2_kbd_rx.

## Test plan
1. Valid frame for scan code 0x1C (data 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz PS/2 clock → exactly one strobe_o, code_o=8'h1C, err_o never high.
2. Two back-to-back frames 0xF0 (parity 1) then 0x1C, no gap → two strobes in order; code_o ends at 8'h1C.
3. Frame 0x1C with parity bit 1 → one err_o pulse, no strobe, code_o holds its previous value. A frame with stop bit 0 gives the same result.
4. Start bit plus 3 data bits, then the clock held high for more than TIMEOUT_CYC cycles → one err_o exactly TIMEOUT_CYC cycles after the last fall. A following 0xF0 frame is received correctly.
5. A 0-pulse of FILTER_LEN−1 cycles on ps2_clk_i while in IDLE → no state change, no outputs. A pulse of FILTER_LEN+1 cycles with data=0 enters DATA.
6. reset_n_i pulsed low after 5 data bits of a frame → outputs return to reset values, no pulses. A complete 0x1C frame afterwards → strobe_o with code_o=8'h1C.
